// File: rtl/uart_wishbone_bridge.sv
// uart_wishbone_bridge
//   Command responder for the host UART debug protocol. It parses byte frames
//   from the UART RX stream, runs Wishbone classic cycles into the SoC, and
//   returns read data on the UART TX stream.
//   Frame layout:
//     CMD (0x01 write / 0x02 read), LEN (word count), ADDR[31:24..7:0].
//     A write frame is followed by LEN words of data, big-endian.
//     A read frame is answered with LEN words of data, big-endian.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     rx_data/rx_valid/rx_ready byte stream from the UART receiver
//     tx_data/tx_valid/tx_ready byte stream to the UART transmitter
//     wb_*                      Wishbone classic master (word addressed)
module uart_wishbone_bridge #(
  parameter int ADDR_WIDTH = 30,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [31:0]           wb_dat_w,
  input  logic [31:0]           wb_dat_r,
  output logic [3:0]            wb_sel,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  input  logic                  wb_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_CMD, S_LEN, S_ADDR, S_WDATA, S_WB_WR, S_WB_RD, S_TX
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic                  we_q, we_d;
  logic [7:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           dat_w_q, dat_w_d;
  logic [31:0]           rdat_q, rdat_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic rx_fire, tx_fire, bus_done;

  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid & tx_ready;
  // A cycle completes on ack, or when cyc has been up for TIMEOUT cycles.
  assign bus_done = wb_ack | (tmo_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CMD;
      bcnt_q  <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
      adr_q   <= '0;
      dat_w_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      we_q    <= we_d;
      len_q   <= len_d;
      adr_q   <= adr_d;
      dat_w_q <= dat_w_d;
      tmo_q   <= tmo_d;
    end
  end

  // Read data holding register: only observed in TX, so no reset needed.
  always_ff @(posedge clk) begin
    rdat_q <= rdat_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    we_d    = we_q;
    len_d   = len_q;
    adr_d   = adr_q;
    dat_w_d = dat_w_q;
    rdat_d  = rdat_q;
    tmo_d   = '0;
    case (state_q)
      S_CMD: begin
        if (rx_fire) begin
          if (rx_data == 8'h01) begin
            we_d    = 1'b1;
            state_d = S_LEN;
          end else if (rx_data == 8'h02) begin
            we_d    = 1'b0;
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (rx_fire) begin
          len_d   = rx_data;
          bcnt_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          // Upper address bytes fall off the top; only ADDR_WIDTH bits kept.
          adr_d  = {adr_q[ADDR_WIDTH-9:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (len_q == 8'd0)  state_d = S_CMD;
            else if (we_q)      state_d = S_WDATA;
            else                state_d = S_WB_RD;
          end
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          dat_w_d = {dat_w_q[23:0], rx_data};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WB_WR;
        end
      end
      S_WB_WR: begin
        if (bus_done) begin
          adr_d   = adr_q + 1'b1;
          len_d   = len_q - 8'd1;
          state_d = (len_q == 8'd1) ? S_CMD : S_WDATA;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WB_RD: begin
        if (bus_done) begin
          rdat_d  = wb_ack ? wb_dat_r : 32'hFFFF_FFFF;
          adr_d   = adr_q + 1'b1;
          len_d   = len_q - 8'd1;
          bcnt_d  = '0;
          state_d = S_TX;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_TX: begin
        if (tx_fire) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = (len_q != 8'd0) ? S_WB_RD : S_CMD;
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  // Output logic
  always_comb begin
    rx_ready = (state_q == S_CMD) || (state_q == S_LEN) ||
               (state_q == S_ADDR) || (state_q == S_WDATA);
    tx_valid = (state_q == S_TX);
    tx_data  = 8'h00;
    if (state_q == S_TX) begin
      case (bcnt_q)
        2'd0:    tx_data = rdat_q[31:24];
        2'd1:    tx_data = rdat_q[23:16];
        2'd2:    tx_data = rdat_q[15:8];
        default: tx_data = rdat_q[7:0];
      endcase
    end
    wb_cyc   = (state_q == S_WB_WR) || (state_q == S_WB_RD);
    wb_stb   = wb_cyc;
    wb_we    = (state_q == S_WB_WR);
    wb_adr   = adr_q;
    wb_dat_w = dat_w_q;
    wb_sel   = 4'hF;
  end

endmodule
